// File: rtl/hpi_target_emu.sv
// hpi_target_emu: 4-register OTG HPI target (DATA/MAILBOX/ADDRESS/STATUS) with local RAM port and mailboxes.
// Optional feature macro HPI_TARGET_PROT_ERR_EN: counts illegal (r_n and w_n both low) accesses in STATUS[15:8].
module hpi_target_emu #(
   parameter int          MEM_AW     = 10,
   parameter logic [15:0] STATUS_RST = 16'h0000
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [1:0]        hpi_address,
   input  logic              hpi_cs_n,
   input  logic              hpi_r_n,
   input  logic              hpi_w_n,
   input  logic [15:0]       hpi_data_in,
   output logic [15:0]       hpi_data_out,
   output logic              hpi_int,
   input  logic              loc_we,
   input  logic [MEM_AW-1:0] loc_addr,
   input  logic [15:0]       loc_wdata,
   output logic [15:0]       loc_rdata,
   output logic [15:0]       mbx_rx_data,
   output logic              mbx_rx_valid,
   input  logic              mbx_rx_ack,
   input  logic [15:0]       mbx_tx_data,
   input  logic              mbx_tx_we
);
   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_HOLD} state_t;
   localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

   state_t            r_state, w_next;
   logic [1:0]        r_sel;
   logic [15:0]       r_wdata;
   logic              r_is_rd;
   logic              r_arm;
   logic [MEM_AW:0]   r_addr;
   logic [15:0]       r_mem [2**MEM_AW];
   logic              r_rx_full, r_tx_full;
   logic [15:0]       r_rx_data, r_tx_data;
   logic [5:0]        r_scratch;
   logic [15:0]       r_dout, r_loc_rdata;
   logic              w_rd_acc, w_wr_acc, w_bus_act;
   logic              w_start, w_wr_commit, w_rd_commit, w_release;
   logic [MEM_AW-1:0] w_raddr;
   logic [15:0]       w_ram_q, w_status, w_rd_mux;
   logic [7:0]        w_err;

   assign w_rd_acc  = !hpi_cs_n && !hpi_r_n && hpi_w_n;
   assign w_wr_acc  = !hpi_cs_n && hpi_r_n && !hpi_w_n;
   assign w_bus_act = !hpi_cs_n && (!hpi_r_n || !hpi_w_n);

   // the host read owns the RAM read port while in RD; otherwise the local port reads
   assign w_raddr  = (r_state == S_RD) ? r_addr[MEM_AW:1] : loc_addr;
   assign w_ram_q  = r_mem[w_raddr];
   assign w_status = {w_err, r_scratch, r_rx_full, r_tx_full};
   assign w_rd_mux = (r_sel == A_DATA) ? w_ram_q :
                     (r_sel == A_MBX)  ? r_tx_data :
                     (r_sel == A_ADDR) ? 16'(r_addr) : w_status;

   // state register
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) r_state <= S_IDLE;
      else                r_state <= w_next;
   end

   // next state and per-state action strobes
   always_comb begin
      w_next      = r_state;
      w_start     = 1'b0;
      w_wr_commit = 1'b0;
      w_rd_commit = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_start = r_arm && (w_rd_acc || w_wr_acc);
            w_next  = w_start ? (w_rd_acc ? S_RD : S_WR) : S_IDLE;
         end
         S_WR: begin
            w_wr_commit = 1'b1;
            w_next      = S_HOLD;
         end
         S_RD: begin
            w_rd_commit = 1'b1;
            w_next      = S_HOLD;
         end
         S_HOLD: begin
            w_release = hpi_cs_n || (r_is_rd ? hpi_r_n : hpi_w_n);
            w_next    = w_release ? S_IDLE : S_HOLD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // register file, mailboxes and output registers; r_arm blocks accesses held across reset or an illegal access
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_arm       <= 1'b0;
         r_sel       <= A_DATA;
         r_wdata     <= '0;
         r_is_rd     <= 1'b0;
         r_addr      <= '0;
         r_rx_full   <= 1'b0;
         r_rx_data   <= '0;
         r_tx_full   <= 1'b0;
         r_tx_data   <= '0;
         r_scratch   <= STATUS_RST[7:2];
         r_dout      <= '0;
         r_loc_rdata <= '0;
      end else begin
         r_arm       <= !w_bus_act;
         r_loc_rdata <= w_ram_q;
         if (w_start) begin
            r_sel   <= hpi_address;
            r_wdata <= hpi_data_in;
            r_is_rd <= w_rd_acc;
         end
         if (w_wr_commit && r_sel == A_ADDR) r_addr <= {r_wdata[MEM_AW:1], 1'b0};
         else if (w_release && r_sel == A_DATA) r_addr <= r_addr + (MEM_AW+1)'(2);
         if (w_wr_commit && r_sel == A_MBX) begin
            r_rx_data <= r_wdata;
            r_rx_full <= 1'b1;
         end else if (mbx_rx_ack) r_rx_full <= 1'b0;
         if (mbx_tx_we) begin
            r_tx_data <= mbx_tx_data;
            r_tx_full <= 1'b1;
         end else if (w_rd_commit && r_sel == A_MBX) r_tx_full <= 1'b0;
         if (w_wr_commit && r_sel == A_STAT) r_scratch <= r_wdata[7:2];
         if (w_rd_commit) r_dout <= w_rd_mux;
      end
   end

   // RAM writes; the host write is issued last so it wins a same-word collision
   always_ff @(posedge clk_clk) begin
      if (reset_reset_n) begin
         if (loc_we) r_mem[loc_addr] <= loc_wdata;
         if (w_wr_commit && r_sel == A_DATA) r_mem[r_addr[MEM_AW:1]] <= r_wdata;
      end
   end

`ifdef HPI_TARGET_PROT_ERR_EN
   logic       w_ill;
   logic [7:0] r_err;
   assign w_ill = !hpi_cs_n && !hpi_r_n && !hpi_w_n;

   // saturating illegal-access counter, counted once per access; STATUS write with bit15 set clears it
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) r_err <= '0;
      else if (w_wr_commit && r_sel == A_STAT && r_wdata[15]) r_err <= '0;
      else if (r_state == S_IDLE && r_arm && w_ill && r_err != 8'hFF) r_err <= r_err + 8'd1;
   end
   assign w_err = r_err;
`else
   assign w_err = 8'h00;
`endif

   assign hpi_data_out = r_dout;
   assign hpi_int      = r_tx_full;
   assign loc_rdata    = r_loc_rdata;
   assign mbx_rx_data  = r_rx_data;
   assign mbx_rx_valid = r_rx_full;
endmodule
